// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial N-digit BCD adder, LSD first, start/busy/done handshake
// Optional subtract mode (ten's complement) enabled by defining BCD_SERIAL_SUB_EN.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a_in,
    input  logic [4*DIGITS-1:0] b_in,
    input  logic                cin,
`ifdef BCD_SERIAL_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_carry;
    logic [IW-1:0]  r_idx;
    logic [W-1:0]   r_sum;
    logic           r_cout;
    logic           r_err;

    logic           w_bad;
    logic [W-1:0]   w_b_eff;
    logic           w_cin_eff;
    logic [4:0]     w_t;
    logic           w_gt9;
    logic [3:0]     w_dig;
    logic           w_last;

    // Operand check always looks at the original inputs, even in subtract mode.
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a_in[4*i +: 4] > 4'd9 || b_in[4*i +: 4] > 4'd9)
                w_bad = 1'b1;
        end
    end

`ifdef BCD_SERIAL_SUB_EN
    always_comb begin
        w_b_eff = b_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (sub)
                w_b_eff[4*i +: 4] = 4'd9 - b_in[4*i +: 4];
        end
    end
    assign w_cin_eff = sub ? 1'b1 : cin;
`else
    assign w_b_eff   = b_in;
    assign w_cin_eff = cin;
`endif

    // Operands shift right each ADD cycle so the active digit is always [3:0].
    assign w_t    = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'd0, r_carry};
    assign w_gt9  = (w_t > 5'd9);
    assign w_dig  = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
    assign w_last = (r_idx == IW'(DIGITS - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = w_bad ? DONE : ADD;
            ADD:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= w_b_eff;
                        r_carry <= w_cin_eff;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_err   <= w_bad;
                    end
                end
                ADD: begin
                    r_sum[4*r_idx +: 4] <= w_dig;
                    r_carry             <= w_gt9;
                    r_a                 <= r_a >> 4;
                    r_b                 <= r_b >> 4;
                    r_idx               <= r_idx + 1'b1;
                    if (w_last)
                        r_cout <= w_gt9;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == ADD);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - directed self-checking bench for bcd_serial_adder (DIGITS=4)
module tb_bcd_serial_adder;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
`ifdef BCD_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulses start (sampled on the following edge), then watches one negedge per
    // cycle until done; latency is counted in cycles after the accepting edge.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input logic inject,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_err);
        int  n;
        int  n_busy;
        bit  seen;
        n = 0;
        n_busy = 0;
        seen = 0;
        @(posedge clk); #1;
        start = 1'b1; a_in = a; b_in = b; cin = c; sub = s;
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (busy) n_busy++;
            if (done) begin
                seen = 1;
                chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
                chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
                chk({tag, "_err"}, 32'(err), 32'(exp_err));
                chk({tag, "_lat"}, n, exp_err ? 1 : DIGITS + 1);
                chk({tag, "_busy"}, n_busy, exp_err ? 0 : DIGITS);
            end else if (inject && n == 1) begin
                @(posedge clk); #1;
                start = 1'b1; a_in = 16'h9999; b_in = 16'h9999; cin = 1'b1;
            end else if (inject && n == 2) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum",  32'(sum),  0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_err",  32'(err),  0);
        @(posedge clk); #1;
        nrst = 1'b1;

        run_op("add1", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_1cyc", 32'(done), 0);
        chk("hold_sum", 32'(sum), 32'h6912);

        run_op("carry_all", 16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("hold_cout", 32'(cout), 1);
        run_op("cin_ripple", 16'h0999, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("top_carry", 16'h8999, 16'h1001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        run_op("bad_digit", 16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_op("bad_b", 16'h0001, 16'hF000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_op("err_clear", 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);

        run_op("ignore_start", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
        run_op("back2back", 16'h4321, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Asynchronous reset after two digits have been written.
        @(posedge clk); #1;
        start = 1'b1; a_in = 16'h1111; b_in = 16'h2222; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("pre_rst_sum", 32'(sum), 32'h0033);
        chk("pre_rst_busy", 32'(busy), 1);
        nrst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_sum",  32'(sum),  0);
        chk("arst_cout", 32'(cout), 0);
        chk("arst_err",  32'(err),  0);
        @(posedge clk); #1;
        nrst = 1'b1;
        run_op("post_rst", 16'h0808, 16'h0202, 1'b0, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

`ifdef BCD_SERIAL_SUB_EN
        run_op("sub_pos", 16'h0500, 16'h0123, 1'b0, 1'b1, 1'b0, 16'h0377, 1'b1, 1'b0);
        run_op("sub_neg", 16'h0123, 16'h0500, 1'b1, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0);
        run_op("sub_bad", 16'h0123, 16'h050B, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
